// File: rtl/hex_event_pkg.sv
// Shared types for the hex event reader: event word layout, the beat carried
// through the output buffer, and the reader FSM state encoding.
package hex_event_pkg;

    localparam int EVT_WIDTH = 64;
    localparam int EVT_DEPTH = 256;

    localparam int EVT_Q_LSB        = 48;
    localparam int EVT_R_LSB        = 32;
    localparam int EVT_DEPTH_LSB    = 24;
    localparam int EVT_MATERIAL_LSB = 16;

    typedef struct packed {
        logic [15:0] q;
        logic [15:0] r;
        logic [7:0]  depth;
        logic [7:0]  material;
        logic [15:0] rsvd;
    } hex_event_t;

    typedef struct packed {
        logic [15:0] q;
        logic [15:0] r;
        logic [7:0]  depth;
        logic [7:0]  material;
        logic        last;
    } beat_t;

    localparam int BEAT_W = $bits(beat_t);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_e;

endpackage

// File: rtl/hex_evt_skid.sv
// Two-entry valid/ready buffer holding unpacked event beats between the
// memory read port and the downstream consumer; occupancy gates read issue.
module hex_evt_skid
    import hex_event_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush_i,
    input  logic              push_i,
    input  logic [BEAT_W-1:0] push_data_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [BEAT_W-1:0] out_data_o,
    output logic [1:0]        count_o
);

    logic [BEAT_W-1:0] slot0_q;
    logic [BEAT_W-1:0] slot1_q;
    logic              wr_ptr_q;
    logic              rd_ptr_q;
    logic [1:0]        count_q;
    logic              pop;

    assign out_valid_o = (count_q != 2'd0);
    assign out_data_o  = rd_ptr_q ? slot1_q : slot0_q;
    assign count_o     = count_q;
    assign pop         = out_valid_o & out_ready_i;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot0_q  <= '0;
            slot1_q  <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else if (flush_i) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (push_i) begin
                if (wr_ptr_q) slot1_q <= push_data_i;
                else          slot0_q <= push_data_i;
                wr_ptr_q <= ~wr_ptr_q;
            end
            if (pop) rd_ptr_q <= ~rd_ptr_q;
            count_q <= count_q + {1'b0, push_i} - {1'b0, pop};
        end
    end

endmodule

// File: rtl/hex_event_reader.sv
// Walks entries 0..N-1 of the event memory after frame_done and streams them as
// unpacked beats. Define HEX_EVT_FILTER_EN to drop entries deeper than depth_limit.
module hex_event_reader
    import hex_event_pkg::*;
#(
    parameter int WIDTH = EVT_WIDTH,
    parameter int DEPTH = EVT_DEPTH,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             frame_done,
    input  logic             frame_abort,
    input  logic [31:0]      write_count,
    input  logic [7:0]       depth_limit,
    output logic             rd_en,
    output logic [AW-1:0]    rd_addr,
    input  logic [WIDTH-1:0] rd_data,
    output logic             ev_valid,
    input  logic             ev_ready,
    output logic [15:0]      ev_q,
    output logic [15:0]      ev_r,
    output logic [7:0]       ev_depth,
    output logic [7:0]       ev_material,
    output logic             ev_last,
    output logic             busy,
    output logic             done,
    output logic [31:0]      read_count,
    output logic [31:0]      drop_count,
    output logic [1:0]       dbg_state
);

    state_e            state_q, state_d;
    logic [31:0]       n_q, n_d;
    logic [31:0]       read_count_q, read_count_d;
    logic [31:0]       drop_count_q, drop_count_d;
    logic              inflight_q, inflight_d;
    logic              inflight_last_q, inflight_last_d;
    logic [31:0]       n_clamped;
    logic [1:0]        occ;
    logic [1:0]        pending;
    logic              pop;
    logic              push;
    logic              keep;
    logic              last_issue;
    hex_event_t        rd_word;
    beat_t             push_beat;
    beat_t             out_beat;
    logic [BEAT_W-1:0] out_bits;
    logic              unused_rsvd;

    assign rd_word.q        = rd_data[EVT_Q_LSB +: 16];
    assign rd_word.r        = rd_data[EVT_R_LSB +: 16];
    assign rd_word.depth    = rd_data[EVT_DEPTH_LSB +: 8];
    assign rd_word.material = rd_data[EVT_MATERIAL_LSB +: 8];
    assign rd_word.rsvd     = rd_data[15:0];
    assign unused_rsvd      = ^rd_word.rsvd;

`ifdef HEX_EVT_FILTER_EN
    assign keep = (rd_word.depth <= depth_limit);
`else
    logic unused_limit;
    assign keep         = 1'b1;
    assign unused_limit = ^depth_limit;
`endif

    assign n_clamped  = (write_count > 32'(DEPTH)) ? 32'(DEPTH) : write_count;
    assign pop        = ev_valid & ev_ready;
    // Slots still claimed after this cycle's pop; a beat leaving now frees room for a read now.
    assign pending    = occ + {1'b0, inflight_q} - {1'b0, pop};
    assign last_issue = (read_count_q == n_q - 32'd1);
    assign push       = inflight_q & keep & ~frame_abort;
    assign push_beat  = '{q: rd_word.q, r: rd_word.r, depth: rd_word.depth,
                          material: rd_word.material, last: inflight_last_q};

    always_comb begin
        state_d         = state_q;
        n_d             = n_q;
        read_count_d    = read_count_q;
        drop_count_d    = drop_count_q;
        inflight_d      = 1'b0;
        inflight_last_d = inflight_last_q;
        rd_en           = 1'b0;
        case (state_q)
            IDLE: begin
                if (frame_done) begin
                    n_d          = n_clamped;
                    read_count_d = 32'd0;
                    drop_count_d = 32'd0;
                    state_d      = (n_clamped == 32'd0) ? DONE : READ;
                end
            end
            READ: begin
                if (pending < 2'd2) begin
                    rd_en           = 1'b1;
                    inflight_d      = 1'b1;
                    inflight_last_d = last_issue;
                    read_count_d    = read_count_q + 32'd1;
                    if (last_issue) state_d = DRAIN;
                end
            end
            DRAIN: begin
                // Leave as the final beat is accepted so done lands right after it.
                if (!inflight_q && (occ == 2'd0 || (occ == 2'd1 && pop))) state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
`ifdef HEX_EVT_FILTER_EN
        if (inflight_q && !keep) drop_count_d = drop_count_d + 32'd1;
`endif
        if (frame_abort) begin
            state_d      = IDLE;
            rd_en        = 1'b0;
            inflight_d   = 1'b0;
            n_d          = n_q;
            read_count_d = read_count_q;
            drop_count_d = drop_count_q;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q         <= IDLE;
            n_q             <= 32'd0;
            read_count_q    <= 32'd0;
            drop_count_q    <= 32'd0;
            inflight_q      <= 1'b0;
            inflight_last_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            n_q             <= n_d;
            read_count_q    <= read_count_d;
            drop_count_q    <= drop_count_d;
            inflight_q      <= inflight_d;
            inflight_last_q <= inflight_last_d;
        end
    end

    hex_evt_skid u_skid (
        .clk         (clk),
        .rst_n       (reset),
        .flush_i     (frame_abort),
        .push_i      (push),
        .push_data_i (push_beat),
        .out_valid_o (ev_valid),
        .out_ready_i (ev_ready),
        .out_data_o  (out_bits),
        .count_o     (occ)
    );

    assign out_beat    = beat_t'(out_bits);
    assign ev_q        = out_beat.q;
    assign ev_r        = out_beat.r;
    assign ev_depth    = out_beat.depth;
    assign ev_material = out_beat.material;
    assign ev_last     = out_beat.last;
    assign rd_addr     = rd_en ? read_count_q[AW-1:0] : '0;
    assign busy        = (state_q != IDLE);
    assign done        = (state_q == DONE);
    assign read_count  = read_count_q;
    assign drop_count  = drop_count_q;
    assign dbg_state   = state_q;

endmodule

// File: tb/tb_hex_event_reader.sv
// Bench for hex_event_reader: a memory model, a queue of expected beats built
// from the memory contents, and one per-cycle compare process.
module tb_hex_event_reader;
  localparam int DEPTH = 256;
  localparam int BW = 49;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic frame_done = 1'b0;
  logic frame_abort = 1'b0;
  logic [31:0] write_count = '0;
  logic [7:0] depth_limit = 8'hFF;
  logic rd_en;
  logic [7:0] rd_addr;
  logic [63:0] rd_data = '0;
  logic ev_valid;
  logic ev_ready = 1'b0;
  logic [15:0] ev_q, ev_r;
  logic [7:0] ev_depth, ev_material;
  logic ev_last, busy, done;
  logic [31:0] read_count, drop_count;
  logic [1:0] dbg_state;

  hex_event_reader dut (
    .clk(clk), .reset(reset), .frame_done(frame_done), .frame_abort(frame_abort),
    .write_count(write_count), .depth_limit(depth_limit), .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_data(rd_data), .ev_valid(ev_valid), .ev_ready(ev_ready), .ev_q(ev_q), .ev_r(ev_r),
    .ev_depth(ev_depth), .ev_material(ev_material), .ev_last(ev_last), .busy(busy),
    .done(done), .read_count(read_count), .drop_count(drop_count), .dbg_state(dbg_state)
  );

  // ---------------- clock / memory ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [63:0] mem [DEPTH];
  always @(posedge clk) if (rd_en) rd_data <= mem[rd_addr];

  // ---------------- scoreboard state ----------------
  int checks = 0;
  int errors = 0;
  logic [BW-1:0] exp_q[$];
  logic [BW-1:0] got_q[$];
  bit mdl_on = 0;
  int n_mdl, next_addr, issued, accepted, dropped, exp_drop;
  int start_cyc = 0;
  int first_rd_rel, first_val_rel, done_rel, valid_cnt, rd_cnt_any, last_addr;
  int done_cnt = 0;
  int pass_done0 = 0;
  bit prev_rd = 0;
  int prev_addr = 0;
  bit hold_p = 0;
  logic [BW-1:0] hold_beat;
  int ready_pct = 100;
  int stall_lo = -1;
  int stall_hi = -1;

  wire [BW-1:0] dut_beat = {ev_q, ev_r, ev_depth, ev_material, ev_last};

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic bit keep_entry(input logic [63:0] w);
`ifdef HEX_EVT_FILTER_EN
    return w[31:24] <= depth_limit;
`else
    return 1'b1;
`endif
  endfunction

  function automatic logic [BW-1:0] beat_of(input logic [63:0] w, input bit last);
    return {w[63:16], last};
  endfunction

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    int rel;
    int outstanding;
    rel = cyc - start_cyc;
    if (done) done_cnt++;
    if (!mdl_on) begin
      hold_p = 0;
      prev_rd = 0;
    end else begin
      if (prev_rd && !keep_entry(mem[prev_addr])) dropped++;
      prev_rd = 0;
      if (hold_p) begin
        check("hold_valid", ev_valid, 1);
        check("hold_fields", dut_beat, hold_beat);
      end
      if (rd_en) begin
        rd_cnt_any++;
        if (first_rd_rel < 0) first_rd_rel = rel;
        check("rd_addr", rd_addr, next_addr);
        check("rd_in_range", next_addr < n_mdl, 1);
        last_addr = rd_addr;
        prev_rd = 1;
        prev_addr = rd_addr;
        next_addr++;
        issued++;
      end
      if (ev_valid) begin
        valid_cnt++;
        if (first_val_rel < 0) first_val_rel = rel;
      end
      if (ev_valid && ev_ready) begin
        accepted++;
        got_q.push_back(dut_beat);
        check("beat_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) check("beat", dut_beat, exp_q.pop_front());
      end
      hold_p = ev_valid && !ev_ready;
      hold_beat = dut_beat;
      outstanding = issued - accepted - dropped;
      check("outstanding_le2", outstanding <= 2, 1);
      if (done) begin
        done_rel = rel;
        check("done_all_beats", exp_q.size(), 0);
        check("done_read_count", read_count, n_mdl);
        check("done_drop_count", drop_count, exp_drop);
        check("done_valid_low", ev_valid, 0);
      end
    end
  end

  // ---------------- ready driver ----------------
  initial forever begin
    int r;
    @(posedge clk);
    #1;
    r = cyc - start_cyc;
    if (r >= stall_lo && r <= stall_hi) ev_ready = 1'b0;
    else ev_ready = ($urandom_range(99) < ready_pct);
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fill_rand(input int n);
    for (int i = 0; i < n && i < DEPTH; i++) mem[i] = {$urandom, $urandom};
  endtask

  task automatic start_pass(input int wc, input int pct, input int slo, input int shi);
    int n;
    n = (wc > DEPTH) ? DEPTH : wc;
    exp_q.delete();
    got_q.delete();
    exp_drop = 0;
    for (int i = 0; i < n; i++) begin
      if (keep_entry(mem[i])) exp_q.push_back(beat_of(mem[i], i == n - 1));
      else exp_drop++;
    end
    n_mdl = n; next_addr = 0; issued = 0; accepted = 0; dropped = 0;
    first_rd_rel = -1; first_val_rel = -1; done_rel = -1; valid_cnt = 0; rd_cnt_any = 0;
    last_addr = -1;
    ready_pct = pct; stall_lo = slo; stall_hi = shi;
    pass_done0 = done_cnt;
    tick();
    start_cyc = cyc;
    write_count = wc;
    frame_done = 1'b1;
    mdl_on = 1;
    tick();
    frame_done = 1'b0;
    write_count = $urandom;
  endtask

  task automatic wait_done(input int budget);
    for (int k = 0; k < budget && done_cnt == pass_done0; k++) tick();
    check("done_seen", done_cnt != pass_done0, 1);
    check("idle_after_done", busy, 0);
    check("done_one_cycle", done, 0);
    mdl_on = 0;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int n, d0;
    #2 reset = 1'b0;
    repeat (3) tick();
    check("rst_rd_en", rd_en, 0);
    check("rst_ev_valid", ev_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_read_count", read_count, 0);
    check("rst_drop_count", drop_count, 0);
    check("rst_state", dbg_state, 0);
    reset = 1'b1;
    tick();

    // N=3, q=1,2,3: fixed latency and ordering
    for (int i = 0; i < 3; i++)
      mem[i] = {16'(i + 1), 16'($urandom), 8'($urandom), 8'($urandom), 16'hBEEF};
    start_pass(3, 100, -1, -1);
    wait_done(100);
    check("t1_first_rd", first_rd_rel, 1);
    check("t1_first_valid", first_val_rel, 3);
    check("t1_valid_cycles", valid_cnt, 3);
    check("t1_done_cycle", done_rel, 6);
    check("t1_read_count", read_count, 3);
    check("t1_beats", got_q.size(), 3);
    if (got_q.size() == 3) begin
      check("t1_q0", got_q[0][48:33], 1);
      check("t1_q1", got_q[1][48:33], 2);
      check("t1_q2", got_q[2][48:33], 3);
      check("t1_last0", got_q[0][0], 0);
      check("t1_last2", got_q[2][0], 1);
    end

    // N=8 with downstream stall on cycles 5..8
    fill_rand(8);
    start_pass(8, 100, 5, 8);
    wait_done(200);
    check("t2_beats", accepted, 8);

    // N=0: straight to done, no reads
    start_pass(0, 100, -1, -1);
    wait_done(20);
    check("t3_done_cycle", done_rel, 1);
    check("t3_no_reads", rd_cnt_any, 0);
    check("t3_no_valid", valid_cnt, 0);

    // write_count above DEPTH clamps
    fill_rand(DEPTH);
    start_pass(300, 100, -1, -1);
    wait_done(1000);
    check("t4_beats", accepted, 256);
    check("t4_last_addr", last_addr, 255);
    check("t4_read_count", read_count, 256);
    if (got_q.size() == 256) begin
      check("t4_last_flag", got_q[255][0], 1);
      check("t4_not_last", got_q[254][0], 0);
    end

    // reset in the middle of an N=10 pass
    fill_rand(10);
    start_pass(10, 100, -1, -1);
    repeat (3) tick();
    mdl_on = 0;
    reset = 1'b0;
    #1;
    check("t5_rd_en", rd_en, 0);
    check("t5_ev_valid", ev_valid, 0);
    check("t5_busy", busy, 0);
    check("t5_read_count", read_count, 0);
    check("t5_rd_addr", rd_addr, 0);
    check("t5_ev_q", ev_q, 0);
    repeat (2) tick();
    reset = 1'b1;
    tick();
    fill_rand(2);
    start_pass(2, 100, -1, -1);
    wait_done(50);
    check("t5_beats", accepted, 2);

    // abort mid-pass, then abort colliding with frame_done
    fill_rand(20);
    start_pass(20, 70, -1, -1);
    repeat ($urandom_range(1, 6)) tick();
    mdl_on = 0;
    frame_abort = 1'b1;
    tick();
    frame_abort = 1'b0;
    check("abort_busy", busy, 0);
    check("abort_valid", ev_valid, 0);
    d0 = done_cnt;
    repeat (5) tick();
    check("abort_no_done", done_cnt, d0);
    frame_abort = 1'b1;
    frame_done = 1'b1;
    write_count = 5;
    tick();
    frame_abort = 1'b0;
    frame_done = 1'b0;
    check("abort_prio_busy", busy, 0);
    tick();
    check("abort_prio_idle", busy, 0);
    fill_rand(5);
    start_pass(5, 80, -1, -1);
    wait_done(200);
    check("post_abort_beats", accepted, 5);

`ifdef HEX_EVT_FILTER_EN
    depth_limit = 8'd10;
    mem[0] = {16'd7, 16'd0, 8'd5, 8'd1, 16'd0};
    mem[1] = {16'd8, 16'd0, 8'd20, 8'd2, 16'd0};
    mem[2] = {16'd9, 16'd0, 8'd10, 8'd3, 16'd0};
    start_pass(3, 100, -1, -1);
    wait_done(100);
    check("t6_beats", accepted, 2);
    check("t6_drop", drop_count, 1);
    if (got_q.size() == 2) begin
      check("t6_depth0", got_q[0][16:9], 5);
      check("t6_depth1", got_q[1][16:9], 10);
      check("t6_last", got_q[1][0], 1);
    end
    start_pass(2, 100, -1, -1);
    wait_done(100);
    check("t6b_beats", accepted, 1);
    if (got_q.size() == 1) check("t6b_no_last", got_q[0][0], 0);
`endif

    // randomized passes, some with a frame_done while busy
    for (int p = 0; p < 12; p++) begin
`ifdef HEX_EVT_FILTER_EN
      depth_limit = 8'($urandom);
`endif
      n = $urandom_range(0, 40);
      fill_rand(n);
      start_pass(n, $urandom_range(30, 100), -1, -1);
      if (n >= 4) begin
        tick();
        frame_done = 1'b1;
        write_count = $urandom_range(1, 50);
        tick();
        frame_done = 1'b0;
      end
      wait_done(1000);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
    $fatal(1, "watchdog");
  end
endmodule
